sd_pattern_loader: RTL

- Sequences the SD-card block reader to fetch a contiguous run of 512-byte blocks holding one Game-of-Life pattern file.
- Unpacks each byte LSB-first into the 1-bit-wide cell RAM, one cell per clock, at consecutive addresses starting at 0.
- Sits between the keyboard file selection, the block reader and the cell RAM, in the SPI clock domain.
- Replaces ad-hoc sequencing in the top level with a start/busy/done handshake.

---
 rtl/sd_pattern_loader_if.sv | 32 +++
 rtl/sd_pattern_loader.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sd_pattern_loader_if.sv
// Start/busy/done handshake, SD block-reader and cell-RAM signals of the pattern loader.
// The master side is the loader itself; the slave side is its environment.
interface sd_pattern_loader_if #(
    parameter int RAM_AW = 24
);
    logic              start;
    logic [3:0]        file_id;
    logic              abort;
    logic              busy;
    logic              done;
    logic              error;
    logic [31:0]       rd_block_id;
    logic              rd_execute;
    logic [1:0]        rd_state;
    logic [8:0]        rd_byte_addr;
    logic [7:0]        rd_byte;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_data;
    logic              ram_wren;

    modport master (
        input  start, file_id, abort, rd_state, rd_byte,
        output busy, done, error, rd_block_id, rd_execute, rd_byte_addr,
               ram_addr, ram_data, ram_wren
    );

    modport slave (
        output start, file_id, abort, rd_state, rd_byte,
        input  busy, done, error, rd_block_id, rd_execute, rd_byte_addr,
               ram_addr, ram_data, ram_wren
    );
endinterface

// File: rtl/sd_pattern_loader.sv
// Fetches BLOCKS_PER_FILE consecutive SD blocks and unpacks every byte LSB-first
// into the 1-bit cell RAM, one cell per clk_spi cycle, starting at address 0.
//
// state    | meaning
// ---------+---------------------------------------------------
// IDLE     | waiting for start
// ISSUE    | one-cycle read command to the block reader
// WAIT_ACK | waiting for the reader to leave a stale FINISH
// WAIT_FIN | waiting for the reader to reach FINISH
// FETCH    | buffer read latency for the current byte
// WRITE    | one cell per cycle, bit 0 first, 8 cycles per byte
// DONE     | one-cycle completion pulse
module sd_pattern_loader #(
    parameter int BLOCKS_PER_FILE = 10,
    parameter int BASE_BLOCK      = 0,
    parameter int RAM_AW          = 24,
    parameter int TIMEOUT_CYCLES  = 2_500_000
) (
    input logic                 clk_spi,
    input logic                 reset,
    sd_pattern_loader_if.master bus
);
    localparam logic [1:0] RD_FINISH = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_FIN,
        FETCH,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       block_id;
    logic [31:0]       block_cnt;
    logic [31:0]       tmo_cnt;
    logic [8:0]        byte_addr;
    logic [2:0]        bit_idx;
    logic [7:0]        byte_q;
    logic [RAM_AW-1:0] cell_addr;
    logic              err_q;

    logic accept;
    logic err_set;
    logic waiting;
    logic timeout;
    logic last_bit;
    logic last_byte;
    logic last_block;

    always_comb begin
        accept     = 1'b0;
        err_set    = 1'b0;
        state_next = state;
        waiting    = (state == WAIT_ACK) || (state == WAIT_FIN);
        timeout    = waiting && (tmo_cnt == 32'd0);
        last_bit   = (bit_idx == 3'd7);
        last_byte  = (byte_addr == 9'd511);
        last_block = (block_cnt >= 32'(BLOCKS_PER_FILE - 1));

        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT_ACK;
            WAIT_ACK: begin
                if (bus.rd_state != RD_FINISH) begin
                    state_next = WAIT_FIN;
                end else if (timeout) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT_FIN: begin
                if (bus.rd_state == RD_FINISH) begin
                    state_next = FETCH;
                end else if (timeout) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end
            end
            FETCH: state_next = WRITE;
            WRITE: begin
                if (last_bit) begin
                    if (!last_byte)       state_next = FETCH;
                    else if (!last_block) state_next = ISSUE;
                    else                  state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Cancel beats every other request, including a start in the same cycle.
        if (bus.abort) begin
            accept     = 1'b0;
            err_set    = 1'b0;
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk_spi or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk_spi or posedge reset) begin
        if (reset) begin
            block_id  <= 32'd0;
            block_cnt <= 32'd0;
            tmo_cnt   <= 32'd0;
            byte_addr <= 9'd0;
            bit_idx   <= 3'd0;
            byte_q    <= 8'd0;
            cell_addr <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                block_id  <= 32'(BASE_BLOCK) + 32'(bus.file_id) * 32'(BLOCKS_PER_FILE);
                block_cnt <= 32'd0;
                cell_addr <= '0;
                err_q     <= 1'b0;
            end
            if (err_set) err_q <= 1'b1;

            // Down-counter spans both wait states; terminal count means timeout.
            if (state == ISSUE)                     tmo_cnt <= 32'(TIMEOUT_CYCLES - 1);
            else if (waiting && tmo_cnt != 32'd0)   tmo_cnt <= tmo_cnt - 32'd1;

            if (state == WAIT_FIN && bus.rd_state == RD_FINISH) byte_addr <= 9'd0;

            if (state == FETCH) begin
                byte_q  <= bus.rd_byte;
                bit_idx <= 3'd0;
            end

            if (state == WRITE) begin
                cell_addr <= cell_addr + RAM_AW'(1);
                bit_idx   <= bit_idx + 3'd1;
                if (last_bit) begin
                    if (!last_byte) begin
                        byte_addr <= byte_addr + 9'd1;
                    end else if (!last_block) begin
                        block_id  <= block_id + 32'd1;
                        block_cnt <= block_cnt + 32'd1;
                    end
                end
            end
        end
    end

    assign bus.busy         = (state != IDLE) && (state != DONE);
    assign bus.done         = (state == DONE);
    assign bus.error        = err_q;
    assign bus.rd_execute   = (state == ISSUE);
    assign bus.rd_block_id  = block_id;
    assign bus.rd_byte_addr = byte_addr;
    assign bus.ram_wren     = (state == WRITE);
    assign bus.ram_data     = (state == WRITE) && byte_q[bit_idx];
    assign bus.ram_addr     = cell_addr;

endmodule
